// File: rtl/edge_relaxer_pkg.sv
// Shared widths, FSM encodings and address helper for the edge relaxation engine.
// Optional feature macro used by this block: RELAX_TIMEOUT_EN.
package edge_relaxer_pkg;

  localparam int unsigned DEFAULT_MADDR_WIDTH    = 16;
  localparam int unsigned DEFAULT_MDATA_WIDTH    = 32;
  localparam int unsigned DEFAULT_NODE_WIDTH     = 8;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_RD_U  = 4'd1,
    S_GAP_U = 4'd2,
    S_RD_V  = 4'd3,
    S_GAP_V = 4'd4,
    S_CMP   = 4'd5,
    S_WR_V  = 4'd6,
    S_GAP_W = 4'd7,
    S_DONE  = 4'd8
  } relax_state_e;

  typedef enum logic [1:0] {
    P_IDLE = 2'd0,
    P_RD   = 2'd1,
    P_WR   = 2'd2,
    P_GAP  = 2'd3
  } port_state_e;

  // Byte address of a distance word; callers truncate to the bus width.
  function automatic int unsigned byte_addr(input int unsigned base,
                                            input int unsigned node,
                                            input int unsigned bytes);
    return base + node * bytes;
  endfunction

endpackage

// File: rtl/edge_relaxer_mem_port.sv
// Single-access BlockRam sequencer: enable/ready handshake, read-data latch, one-cycle gap.
// RELAX_TIMEOUT_EN adds a per-access ready-wait limit that aborts the access.
module edge_relaxer_mem_port
  import edge_relaxer_pkg::*;
#(
  parameter int unsigned AW = DEFAULT_MADDR_WIDTH,
  parameter int unsigned DW = DEFAULT_MDATA_WIDTH
`ifdef RELAX_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cmd_rd_i,
  input  logic          cmd_wr_i,
  input  logic [AW-1:0] cmd_addr_i,
  input  logic [DW-1:0] cmd_wdata_i,
  output logic          ack_c_o,
  output logic          timeout_c_o,
  output logic [DW-1:0] rdata_o,
  output logic          mem_read_enable_o,
  output logic          mem_write_enable_o,
  input  logic          mem_read_ready_i,
  input  logic          mem_write_ready_i,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_write_data_o,
  input  logic [DW-1:0] mem_read_data_i
);

  port_state_e   state_q, state_d;
  logic          rd_en_q, rd_en_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

`ifdef RELAX_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= P_IDLE;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef RELAX_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef RELAX_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Commands are accepted in IDLE or during the gap cycle; enables only rise afterwards.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    ack_c_o     = 1'b0;
    timeout_c_o = 1'b0;
`ifdef RELAX_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      P_IDLE, P_GAP: begin
        state_d = P_IDLE;
        if (cmd_rd_i) begin
          state_d = P_RD;
          addr_d  = cmd_addr_i;
`ifdef RELAX_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (cmd_wr_i) begin
          state_d = P_WR;
          addr_d  = cmd_addr_i;
          wdata_d = cmd_wdata_i;
`ifdef RELAX_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      P_RD, P_WR: begin
        if ((state_q == P_RD) ? mem_read_ready_i : mem_write_ready_i) begin
          ack_c_o = 1'b1;
          state_d = P_GAP;
          if (state_q == P_RD) begin
            rdata_d = mem_read_data_i;
          end
        end
`ifdef RELAX_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          timeout_c_o = 1'b1;
          state_d     = P_GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      default: state_d = P_IDLE;
    endcase
    rd_en_d = (state_d == P_RD);
    wr_en_d = (state_d == P_WR);
  end

  assign mem_read_enable_o  = rd_en_q;
  assign mem_write_enable_o = wr_en_q;
  assign mem_addr_o         = addr_q;
  assign mem_write_data_o   = wdata_q;
  assign rdata_o            = rdata_q;

endmodule

// File: rtl/edge_relaxer.sv
// Dijkstra edge relaxation: dist[v] = min(dist[v], sat(dist[u] + weight)) via BlockRam.
// RELAX_TIMEOUT_EN enables the ready-wait abort path and the error output.
module edge_relaxer
  import edge_relaxer_pkg::*;
#(
  parameter int unsigned MADDR_WIDTH = DEFAULT_MADDR_WIDTH,
  parameter int unsigned MDATA_WIDTH = DEFAULT_MDATA_WIDTH,
  parameter int unsigned NODE_WIDTH  = DEFAULT_NODE_WIDTH,
  parameter int unsigned BASE_ADDR   = 0
`ifdef RELAX_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NODE_WIDTH-1:0]  node_u,
  input  logic [NODE_WIDTH-1:0]  node_v,
  input  logic [MDATA_WIDTH-1:0] weight,
  output logic                   busy,
  output logic                   done,
  output logic                   updated,
  output logic [MDATA_WIDTH-1:0] new_dist,
  output logic                   error,
  output logic                   mem_read_enable,
  output logic                   mem_write_enable,
  input  logic                   mem_write_ready,
  input  logic                   mem_read_ready,
  output logic [MADDR_WIDTH-1:0] mem_addr,
  input  logic [MDATA_WIDTH-1:0] mem_read_data,
  output logic [MDATA_WIDTH-1:0] mem_write_data
);

  localparam int unsigned             DBYTES   = MDATA_WIDTH / 8;
  localparam logic [MDATA_WIDTH-1:0] DIST_INF = '1;

  relax_state_e           state_q, state_d;
  logic [NODE_WIDTH-1:0]  node_u_q, node_u_d;
  logic [NODE_WIDTH-1:0]  node_v_q, node_v_d;
  logic [MDATA_WIDTH-1:0] weight_q, weight_d;
  logic [MDATA_WIDTH-1:0] dist_u_q, dist_u_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   updated_q, updated_d;
  logic [MDATA_WIDTH-1:0] new_dist_q, new_dist_d;
  logic                   error_q, error_d;

  logic                   cmd_rd_c, cmd_wr_c;
  logic [MADDR_WIDTH-1:0] cmd_addr_c;
  logic [MDATA_WIDTH-1:0] cmd_wdata_c;
  logic                   ack_c, timeout_c;
  logic [MDATA_WIDTH-1:0] port_rdata;
  logic [MDATA_WIDTH:0]   cand_c;
  logic [MDATA_WIDTH-1:0] cand_sat_c;
  logic                   relax_c;

  function automatic logic [MADDR_WIDTH-1:0] node_addr(input logic [NODE_WIDTH-1:0] n);
    return MADDR_WIDTH'(byte_addr(BASE_ADDR, 32'(n), DBYTES));
  endfunction

  // One extra bit catches the carry so the sum saturates instead of wrapping.
  assign cand_c     = {1'b0, dist_u_q} + {1'b0, weight_q};
  assign cand_sat_c = cand_c[MDATA_WIDTH] ? DIST_INF : cand_c[MDATA_WIDTH-1:0];
  assign relax_c    = (dist_u_q != DIST_INF) && (cand_sat_c < port_rdata);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      node_u_q   <= '0;
      node_v_q   <= '0;
      weight_q   <= '0;
      dist_u_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      updated_q  <= 1'b0;
      new_dist_q <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      node_u_q   <= node_u_d;
      node_v_q   <= node_v_d;
      weight_q   <= weight_d;
      dist_u_q   <= dist_u_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      updated_q  <= updated_d;
      new_dist_q <= new_dist_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    node_u_d    = node_u_q;
    node_v_d    = node_v_q;
    weight_d    = weight_q;
    dist_u_d    = dist_u_q;
    cmd_rd_c    = 1'b0;
    cmd_wr_c    = 1'b0;
    cmd_addr_c  = '0;
    cmd_wdata_c = '0;
    updated_d   = 1'b0;
    new_dist_d  = '0;
    error_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RD_U;
          node_u_d   = node_u;
          node_v_d   = node_v;
          weight_d   = weight;
          cmd_rd_c   = 1'b1;
          cmd_addr_c = node_addr(node_u);
        end
      end
      S_RD_U: begin
        if (ack_c) begin
          state_d = S_GAP_U;
        end else if (timeout_c) begin
          state_d = S_DONE;
          error_d = 1'b1;
        end
      end
      S_GAP_U: begin
        dist_u_d   = port_rdata;
        state_d    = S_RD_V;
        cmd_rd_c   = 1'b1;
        cmd_addr_c = node_addr(node_v_q);
      end
      S_RD_V: begin
        if (ack_c) begin
          state_d = S_GAP_V;
        end else if (timeout_c) begin
          state_d = S_DONE;
          error_d = 1'b1;
        end
      end
      S_GAP_V: state_d = S_CMP;
      // port_rdata still holds dist[v] here; ties keep the old value.
      S_CMP: begin
        if (relax_c) begin
          state_d     = S_WR_V;
          cmd_wr_c    = 1'b1;
          cmd_addr_c  = node_addr(node_v_q);
          cmd_wdata_c = cand_sat_c;
        end else begin
          state_d    = S_DONE;
          new_dist_d = port_rdata;
        end
      end
      S_WR_V: begin
        if (ack_c) begin
          state_d = S_GAP_W;
        end else if (timeout_c) begin
          state_d = S_DONE;
          error_d = 1'b1;
        end
      end
      S_GAP_W: begin
        state_d    = S_DONE;
        updated_d  = 1'b1;
        new_dist_d = mem_write_data;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  edge_relaxer_mem_port #(
    .AW (MADDR_WIDTH),
    .DW (MDATA_WIDTH)
`ifdef RELAX_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
  ) u_mem_port (
    .clk_i              (clock),
    .rst_ni             (reset),
    .cmd_rd_i           (cmd_rd_c),
    .cmd_wr_i           (cmd_wr_c),
    .cmd_addr_i         (cmd_addr_c),
    .cmd_wdata_i        (cmd_wdata_c),
    .ack_c_o            (ack_c),
    .timeout_c_o        (timeout_c),
    .rdata_o            (port_rdata),
    .mem_read_enable_o  (mem_read_enable),
    .mem_write_enable_o (mem_write_enable),
    .mem_read_ready_i   (mem_read_ready),
    .mem_write_ready_i  (mem_write_ready),
    .mem_addr_o         (mem_addr),
    .mem_write_data_o   (mem_write_data),
    .mem_read_data_i    (mem_read_data)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign updated  = updated_q;
  assign new_dist = new_dist_q;
  assign error    = error_q;

endmodule

// File: tb/tb_edge_relaxer.sv
// Directed, table-driven bench for edge_relaxer (16-bit distances) with a latency-programmable RAM.
// With RELAX_TIMEOUT_EN defined the stalled-RAM sequence checks the timeout abort.
module tb_edge_relaxer;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned NW = 8;
  localparam logic [15:0] INF = 16'hFFFF;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [NW-1:0] node_u = '0;
  logic [NW-1:0] node_v = '0;
  logic [DW-1:0] weight = '0;
  logic          busy, done, updated, error;
  logic [DW-1:0] new_dist;
  logic          mem_read_enable, mem_write_enable;
  logic          mem_read_ready, mem_write_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_read_data, mem_write_data;

  edge_relaxer #(
    .MADDR_WIDTH (AW),
    .MDATA_WIDTH (DW),
    .NODE_WIDTH  (NW),
    .BASE_ADDR   (0)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .node_u           (node_u),
    .node_v           (node_v),
    .weight           (weight),
    .busy             (busy),
    .done             (done),
    .updated          (updated),
    .new_dist         (new_dist),
    .error            (error),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_write_ready  (mem_write_ready),
    .mem_read_ready   (mem_read_ready),
    .mem_addr         (mem_addr),
    .mem_read_data    (mem_read_data),
    .mem_write_data   (mem_write_data)
  );

  always #5 clock = ~clock;

  // RAM model: ready after 'lat' waiting cycles, never while 'stall' is set.
  logic [15:0] ram [65536];
  int lat = 0;
  bit stall = 1'b0;
  int wcnt = 0;
  int wr_count = 0;
  int done_cnt = 0;
  int viol = 0;
  int cyc_now = 0;
  int acc_cyc = 0;

  assign mem_read_data   = ram[mem_addr >> 1];
  assign mem_read_ready  = mem_read_enable && !stall && (wcnt >= lat);
  assign mem_write_ready = mem_write_enable && !stall && (wcnt >= lat);

  always @(posedge clock) begin
    cyc_now <= cyc_now + 1;
    if (!reset) wcnt <= 0;
    else if ((mem_read_enable && !mem_read_ready) || (mem_write_enable && !mem_write_ready))
      wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (reset && mem_write_enable && mem_write_ready) begin
      ram[mem_addr >> 1] <= mem_write_data;
      wr_count <= wr_count + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  // Handshake monitor: exclusive enables, stable address/data, one idle cycle after each access.
  logic          prev_ack = 1'b0;
  logic          prev_wait = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_wd = '0;
  always @(posedge clock) begin
    if (!reset) begin
      prev_ack  <= 1'b0;
      prev_wait <= 1'b0;
    end else begin
      if ((mem_read_enable && mem_write_enable) ||
          (prev_ack && (mem_read_enable || mem_write_enable)) ||
          (prev_wait && (mem_read_enable || mem_write_enable) &&
           ((mem_addr != prev_addr) || (mem_write_enable && mem_write_data != prev_wd))))
        viol <= viol + 1;
      prev_ack  <= (mem_read_enable && mem_read_ready) || (mem_write_enable && mem_write_ready);
      prev_wait <= (mem_read_enable && !mem_read_ready) || (mem_write_enable && !mem_write_ready);
      prev_addr <= mem_addr;
      prev_wd   <= mem_write_data;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [NW-1:0] u, input logic [NW-1:0] v, input logic [DW-1:0] w);
    @(negedge clock);
    node_u = u;
    node_v = v;
    weight = w;
    start  = 1'b1;
    @(posedge clock);
    #1;
    start   = 1'b0;
    acc_cyc = cyc_now;
  endtask

  task automatic wait_done(output int lat_o, output bit got);
    got = 1'b0;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(posedge clock);
      #1;
      if (done) got = 1'b1;
    end
    lat_o = cyc_now - acc_cyc;
  endtask

  typedef struct {
    logic [7:0]  u;
    logic [7:0]  v;
    logic [15:0] du;
    logic [15:0] dv;
    logic [15:0] w;
    logic        upd;
    logic [15:0] nd;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc, w0, d0, exp_lat;
    bit  got;
    vecs[0]  = '{8'd3,   8'd7,   16'd10,    16'd50,    16'd15,    1'b1, 16'd25,    0};
    vecs[1]  = '{8'd3,   8'd7,   16'd10,    16'd25,    16'd15,    1'b0, 16'd25,    2};
    vecs[2]  = '{8'd3,   8'd7,   INF,       INF,       16'd1,     1'b0, INF,       0};
    vecs[3]  = '{8'd1,   8'd2,   16'hFFF0,  INF,       16'h0020,  1'b0, INF,       1};
    vecs[4]  = '{8'd1,   8'd2,   16'hFFF0,  INF,       16'h000E,  1'b1, 16'hFFFE,  0};
    vecs[5]  = '{8'd5,   8'd5,   16'd100,   16'd100,   16'd0,     1'b0, 16'd100,   0};
    vecs[6]  = '{8'd0,   8'd255, 16'd0,     16'd1,     16'd0,     1'b1, 16'd0,     1};
    vecs[7]  = '{8'd4,   8'd9,   16'd5,     16'd10,    16'd5,     1'b0, 16'd10,    0};
    vecs[8]  = '{8'd4,   8'd9,   16'd0,     INF,       INF,       1'b0, INF,       0};
    vecs[9]  = '{8'd4,   8'd9,   16'd0,     INF,       16'hFFFE,  1'b1, 16'hFFFE,  3};
    vecs[10] = '{8'd200, 8'd100, 16'd7,     16'd9,     16'd1,     1'b1, 16'd8,     0};

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_updated", 32'(updated), 32'd0);
    check("rst_new_dist", 32'(new_dist), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_rd_en", 32'(mem_read_enable), 32'd0);
    check("rst_wr_en", 32'(mem_write_enable), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_write_data), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    foreach (vecs[i]) begin
      ram[16'(vecs[i].u)] = vecs[i].du;
      ram[16'(vecs[i].v)] = vecs[i].dv;
      lat = vecs[i].lat;
      w0  = wr_count;
      start_op(vecs[i].u, vecs[i].v, vecs[i].w);
      check($sformatf("v%0d_busy_start", i), 32'(busy), 32'd1);
      wait_done(cyc, got);
      exp_lat = 5 + 2 * int'(vecs[i].upd) + vecs[i].lat * (2 + int'(vecs[i].upd));
      check($sformatf("v%0d_done", i), 32'(got), 32'd1);
      check($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'd0);
      check($sformatf("v%0d_updated", i), 32'(updated), 32'(vecs[i].upd));
      check($sformatf("v%0d_new_dist", i), 32'(new_dist), 32'(vecs[i].nd));
      check($sformatf("v%0d_error", i), 32'(error), 32'd0);
      check($sformatf("v%0d_latency", i), 32'(cyc), 32'(exp_lat));
      @(posedge clock);
      #1;
      check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      check($sformatf("v%0d_ram_v", i), 32'(ram[16'(vecs[i].v)]), 32'(vecs[i].nd));
      check($sformatf("v%0d_writes", i), 32'(wr_count - w0), 32'(vecs[i].upd));
    end

    // start pulses while busy are ignored and not queued
    ram[0] = 16'd0; ram[3] = 16'd10; ram[7] = 16'd50;
    lat = 1;
    d0  = done_cnt;
    start_op(8'd3, 8'd7, 16'd15);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      start = 1'b1; node_u = 8'd0; node_v = 8'd3; weight = 16'd0;
      @(negedge clock);
      start = 1'b0;
    end
    wait_done(cyc, got);
    check("busy_ign_done", 32'(got), 32'd1);
    check("busy_ign_new_dist", 32'(new_dist), 32'd25);
    check("busy_ign_updated", 32'(updated), 32'd1);
    // start held during the DONE cycle is dropped too
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    check("done_cycle_start_busy", 32'(busy), 32'd0);
    repeat (15) @(posedge clock);
    #1;
    check("busy_ign_one_done", 32'(done_cnt - d0), 32'd1);
    check("busy_ign_ram3", 32'(ram[3]), 32'd10);
    check("busy_ign_ram7", 32'(ram[7]), 32'd25);

    // Asynchronous reset in the middle of the dist[v] read
    ram[3] = 16'd10; ram[7] = 16'd50;
    lat = 3;
    start_op(8'd3, 8'd7, 16'd15);
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(posedge clock);
      #1;
      if (mem_read_enable && mem_addr == 16'd14) got = 1'b1;
    end
    check("rst_mid_reached_rd_v", 32'(got), 32'd1);
    d0 = done_cnt;
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_rd_en", 32'(mem_read_enable), 32'd0);
    check("rst_mid_wr_en", 32'(mem_write_enable), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clock);
    #1;
    check("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
    check("rst_mid_ram7", 32'(ram[7]), 32'd50);
    @(negedge clock);
    reset = 1'b1;
    lat = 0;
    start_op(8'd3, 8'd7, 16'd15);
    wait_done(cyc, got);
    check("post_rst_done", 32'(got), 32'd1);
    check("post_rst_new_dist", 32'(new_dist), 32'd25);
    repeat (4) @(posedge clock);
    #1;
    check("post_rst_done_once", 32'(done_cnt - d0), 32'd1);

`ifdef RELAX_TIMEOUT_EN
    // Stalled RAM: abort after the ready-wait limit with error set
    ram[3] = 16'd10; ram[7] = 16'd50;
    stall = 1'b1;
    w0 = wr_count;
    d0 = done_cnt;
    start_op(8'd3, 8'd7, 16'd15);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      start = 1'b1; node_u = 8'd0; node_v = 8'd7; weight = 16'd0;
      @(negedge clock);
      start = 1'b0;
    end
    wait_done(cyc, got);
    check("tmo_done", 32'(got), 32'd1);
    check("tmo_error", 32'(error), 32'd1);
    check("tmo_updated", 32'(updated), 32'd0);
    check("tmo_new_dist", 32'(new_dist), 32'd0);
    check("tmo_latency", 32'(cyc), 32'd255);
    stall = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    check("tmo_idle_busy", 32'(busy), 32'd0);
    check("tmo_rd_en", 32'(mem_read_enable), 32'd0);
    check("tmo_no_write", 32'(wr_count - w0), 32'd0);
    check("tmo_one_done", 32'(done_cnt - d0), 32'd1);
`else
    // Stalled RAM: enable and address held while waiting, then completes normally
    ram[3] = 16'd10; ram[7] = 16'd50;
    stall = 1'b1;
    start_op(8'd3, 8'd7, 16'd15);
    repeat (20) @(posedge clock);
    #1;
    check("stall_rd_en_held", 32'(mem_read_enable), 32'd1);
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_addr", 32'(mem_addr), 32'd6);
    check("stall_no_done", 32'(done), 32'd0);
    stall = 1'b0;
    wait_done(cyc, got);
    check("stall_done", 32'(got), 32'd1);
    check("stall_new_dist", 32'(new_dist), 32'd25);
    check("stall_error", 32'(error), 32'd0);
`endif

    check("protocol_violations", 32'(viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
